fir_uart_sequencer: RTL and testbench
=====================================

# fir_uart_sequencer

Sequences the FIR core against the UART byte stream. Assembles two received bytes into one WIDTH-bit sample, launches a single FIR computation with a one-cycle start pulse, and waits for the core's result strobe. It then serializes the OUT_WIDTH-bit result LSB-first to the UART transmitter under a valid/ready handshake. Sits between the UART RX/TX blocks and the FIR top; it is the only master of the FIR core's input strobe.

## Interface
- WIDTH, 16, sample width; fixed at 2 bytes.
- OUT_WIDTH, 38, FIR result width; transmitted as OUT_BYTES = ceil(OUT_WIDTH/8) bytes (5 at default).
- LENGTH, 64, FIR tap count; informational, used for the TIMEOUT default.
- TIMEOUT, LENGTH+8, WAIT-state cycle limit; used only with FIR_SEQ_TIMEOUT_EN.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- fir_in  out  WIDTH  sample to the FIR core.
- fir_valid  out  1  one-cycle FIR start pulse.
- fir_out  in  OUT_WIDTH  FIR result; two's complement.
- fir_out_valid  in  1  FIR result strobe.
- tx_data  out  8  byte to the transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  one-cycle pulse when a received byte is dropped.
- timeout  out  1  one-cycle pulse when the FIR result does not arrive in time; tied 0 without the macro.

## Operation
- Reset value of all outputs and registers is 0; state is IDLE. Reset mid-operation discards any partial sample, pending result and in-progress transmit.
- State machine:
  - IDLE: on rx_valid, latch rx_data as sample[7:0] and go to LOW.
  - LOW: on rx_valid, latch rx_data as sample[15:8] and go to START. There is no inter-byte timeout.
  - START: fir_valid = 1 for exactly this cycle; fir_in holds the sample. Always goes to WAIT.
  - WAIT: on fir_out_valid, capture fir_out into the shift register, set byte index to 0, go to SEND.
  - SEND: tx_valid = 1; tx_data = shift[7:0]. On tx_valid && tx_ready, shift right by 8 and increment the index. On the handshake of byte OUT_BYTES-1, go to IDLE.
- Sign extension: bits above OUT_WIDTH-1 in the last byte are filled with fir_out[OUT_WIDTH-1].
- Overrun: rx_valid in START, WAIT or SEND drops the byte and pulses overrun in the next cycle. State and data are unaffected.
- fir_out_valid outside WAIT is ignored.
- fir_in holds its value after START until the next sample completes.

## Timing
- High byte accepted (rx_valid in LOW) in cycle n -> fir_valid high in cycle n+1 only.
- fir_out_valid in cycle m -> tx_valid high with byte 0 in cycle m+1.
- While tx_valid && !tx_ready, tx_data is held stable. Byte k+1 appears in the cycle after the handshake of byte k, so the zero-stall throughput is one byte per cycle.
- After the final handshake, the next cycle is IDLE: busy = 0, tx_valid = 0. An rx_valid in that cycle is accepted.
- All outputs are registered and come from flops; there are no combinational paths from inputs to outputs.

## Configuration
- FIR_SEQ_TIMEOUT_EN defined:
  - A wait counter is cleared on entry to WAIT and increments each WAIT cycle.
  - If the count reaches TIMEOUT-1 without fir_out_valid, timeout pulses for one cycle, the state returns to IDLE and nothing is transmitted.
  - If fir_out_valid arrives in the same cycle as the limit, the result wins.
- Undefined: WAIT persists indefinitely, timeout is constant 0, and no counter is instantiated.

## Structure
- Package fir_seq_pkg holds:
  - the state enum (IDLE, LOW, START, WAIT, SEND);
  - the function computing OUT_BYTES from OUT_WIDTH;
  - the byte width constant.
- One sub-module, fir_seq_tx_shifter: OUT_BYTES*8 shift register with a byte index, load/advance inputs and a last-byte flag.
- FSM, sample assembly and timeout counter stay in the top module.

## Test plan
- Send rx bytes 0x34 then 0x12 -> fir_in = 0x1234 and fir_valid high for exactly 1 cycle, in the cycle after the second rx_valid.
- Return fir_out = 38'h00_0000_0102 with tx_ready = 1 -> tx bytes 0x02, 0x01, 0x00, 0x00, 0x00 on consecutive cycles, then busy = 0.
- Return fir_out = 38'h3F_FFFF_FFFE (-2) -> tx bytes 0xFE, 0xFF, 0xFF, 0xFF, 0xFF; this checks sign extension of the top byte.
- Hold tx_ready = 0 for 3 cycles while byte 0 is 0x02 -> tx_data stays 0x02 and tx_valid stays 1; byte 1 appears the cycle after tx_ready rises.
- Pulse rx_valid with 0xAA during WAIT -> overrun pulses once, the result is still sent unchanged, and the next sample starts cleanly in IDLE.
- With FIR_SEQ_TIMEOUT_EN and TIMEOUT = 72, never assert fir_out_valid -> timeout pulses after 72 WAIT cycles, no tx_valid, state IDLE.
- Separately, assert rst mid-SEND -> all outputs are 0 immediately, and the next two bytes form a fresh sample.

Source files
------------

// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared types and constants for the FIR/UART sequencer
// Contents: sequencer state enum, byte width, result byte-count helper.
package fir_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOW   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        SEND  = 3'd4
    } state_t;

    // Number of UART bytes needed to carry an out_width-bit result.
    function automatic int calc_out_bytes(input int out_width);
        return (out_width + BYTE_W - 1) / BYTE_W;
    endfunction

endpackage

// File: rtl/fir_seq_tx_shifter.sv
// rtl/fir_seq_tx_shifter.sv - byte-serializing shift register for the FIR result
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        capture load_data and restart the byte index at 0
//   load_data   OUT_BYTES*8-bit result, already sign-extended
//   advance     shift right one byte and bump the index
//   tx_byte     current low byte of the shift register
//   last        index points at the final byte
module fir_seq_tx_shifter
    import fir_seq_pkg::*;
#(
    parameter int OUT_BYTES = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic [OUT_BYTES*BYTE_W-1:0] load_data,
    input  logic                        advance,
    output logic [BYTE_W-1:0]           tx_byte,
    output logic                        last
);

    localparam int SHW   = OUT_BYTES * BYTE_W;
    localparam int IDX_W = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;

    logic [SHW-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (load) begin
            shift_d = load_data;
            idx_d   = '0;
        end else if (advance) begin
            shift_d = shift_q >> BYTE_W;
            idx_d   = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign tx_byte = shift_q[BYTE_W-1:0];
    assign last    = (idx_q == IDX_W'(OUT_BYTES - 1));

endmodule

// File: rtl/fir_uart_sequencer.sv
// rtl/fir_uart_sequencer.sv - sequences UART byte pairs into FIR runs and streams results back
// Optional feature macro: FIR_SEQ_TIMEOUT_EN (WAIT-state result timeout).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rx_data, rx_valid        received byte strobe
//   fir_in, fir_valid        sample and one-cycle start pulse to the FIR core
//   fir_out, fir_out_valid   FIR result and its strobe
//   tx_data, tx_valid, tx_ready  result bytes to the transmitter, LSB first
//   busy                     any state other than IDLE
//   overrun                  pulse: a received byte was dropped
//   timeout                  pulse: FIR result did not arrive in time (0 without the macro)
module fir_uart_sequencer
    import fir_seq_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 38,
    parameter int LENGTH    = 64,
    parameter int TIMEOUT   = LENGTH + 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BYTE_W-1:0]    rx_data,
    input  logic                 rx_valid,
    output logic [WIDTH-1:0]     fir_in,
    output logic                 fir_valid,
    input  logic [OUT_WIDTH-1:0] fir_out,
    input  logic                 fir_out_valid,
    output logic [BYTE_W-1:0]    tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout
);

    localparam int OUT_BYTES = calc_out_bytes(OUT_WIDTH);
    localparam int SHW       = OUT_BYTES * BYTE_W;

    state_t            state_q, state_d;
    logic [BYTE_W-1:0] sample_lo_q, sample_lo_d;
    logic [WIDTH-1:0]  fir_in_q, fir_in_d;
    logic              fir_valid_q, tx_valid_q, busy_q;
    logic              overrun_q, overrun_d;
    logic              sh_load, sh_advance, sh_last;
    logic [SHW-1:0]    load_data;
    logic              timeout_hit;

    // Signed cast makes the padding bits of the top byte copies of the sign bit.
    assign load_data = SHW'($signed(fir_out));

`ifdef FIR_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q;

    // Counter is zero outside WAIT, so it is already clear on entry.
    always_comb begin
        wait_cnt_d = '0;
        if (state_q == WAIT) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // A result arriving on the limit cycle takes priority over the timeout.
    assign timeout_hit = (state_q == WAIT) && !fir_out_valid &&
                         (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_hit;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        sample_lo_d = sample_lo_q;
        fir_in_d    = fir_in_q;
        sh_load     = 1'b0;
        sh_advance  = 1'b0;
        overrun_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    sample_lo_d = rx_data;
                    state_d     = LOW;
                end
            end
            LOW: begin
                // fir_in only changes when a full sample is assembled.
                if (rx_valid) begin
                    fir_in_d = WIDTH'({rx_data, sample_lo_q});
                    state_d  = START;
                end
            end
            START: begin
                overrun_d = rx_valid;
                state_d   = WAIT;
            end
            WAIT: begin
                overrun_d = rx_valid;
                if (fir_out_valid) begin
                    sh_load = 1'b1;
                    state_d = SEND;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                overrun_d = rx_valid;
                if (tx_valid_q && tx_ready) begin
                    sh_advance = 1'b1;
                    if (sh_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobe outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sample_lo_q <= '0;
            fir_in_q    <= '0;
            fir_valid_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sample_lo_q <= sample_lo_d;
            fir_in_q    <= fir_in_d;
            fir_valid_q <= (state_d == START);
            tx_valid_q  <= (state_d == SEND);
            busy_q      <= (state_d != IDLE);
            overrun_q   <= overrun_d;
        end
    end

    fir_seq_tx_shifter #(
        .OUT_BYTES (OUT_BYTES)
    ) u_tx_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (sh_load),
        .load_data (load_data),
        .advance   (sh_advance),
        .tx_byte   (tx_data),
        .last      (sh_last)
    );

    assign fir_in    = fir_in_q;
    assign fir_valid = fir_valid_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_uart_sequencer.sv
// tb/tb_fir_uart_sequencer.sv - self-checking bench for fir_uart_sequencer
module tb_fir_uart_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [15:0] fir_in;
    logic        fir_valid;
    logic [37:0] fir_out;
    logic        fir_out_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        overrun;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_samples[$];
    logic [7:0]  exp_bytes[$];
    bit          in_flight  = 1'b0;
    bit          ovr_exp    = 1'b0;
    bit          prev_fv    = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    always #5 clk = ~clk;

    fir_uart_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .fir_in        (fir_in),
        .fir_valid     (fir_valid),
        .fir_out       (fir_out),
        .fir_out_valid (fir_out_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .overrun       (overrun),
        .timeout       (timeout)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Byte k of the two's-complement value of v, as plain integer arithmetic.
    function automatic logic [7:0] model_byte(input logic [37:0] v, input int k);
        longint s = longint'(v);
        if (v[37]) s = s - (longint'(1) << 38);
        return 8'((s >> (8 * k)) & 255);
    endfunction

    // Transaction-level compare on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            ovr_exp    = 1'b0;
            prev_fv    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("overrun", overrun, ovr_exp);
            ovr_exp = rx_valid && in_flight;
            if (fir_valid) begin
                check("fir_valid_single", prev_fv, 0);
                if (exp_samples.size() == 0) fail_now("fir_valid_unexpected");
                else check("fir_in", fir_in, exp_samples.pop_front());
            end
            prev_fv = fir_valid;
            if (prev_stall) begin
                check("tx_hold_valid", tx_valid, 1);
                check("tx_hold_data", tx_data, prev_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_bytes.size() == 0) fail_now("tx_unexpected");
                else check("tx_byte", tx_data, exp_bytes.pop_front());
                if (exp_bytes.size() == 0) in_flight = 1'b0;
            end
            check("timeout_idle", timeout, 0);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    // Low byte, gap cycles (with stray result strobes), high byte, then START checks.
    task automatic send_sample(input logic [15:0] s, input int gap, input bit noise, input bit ovr_start);
        send_byte(s[7:0]);
        for (int i = 0; i < gap; i++) begin
            fir_out_valid = noise && ($urandom_range(1) == 1);
            fir_out       = 38'h2A_AAAA_AAAA;
            tick();
        end
        fir_out_valid = 1'b0;
        exp_samples.push_back(s);
        send_byte(s[15:8]);
        in_flight = 1'b1;
        check("fir_valid_n1", fir_valid, 1);
        check("fir_in_n1", fir_in, s);
        check("busy_start", busy, 1);
        if (ovr_start) begin
            rx_data  = 8'($urandom);
            rx_valid = 1'b1;
        end
        tick();
        rx_valid = 1'b0;
        check("fir_valid_n2", fir_valid, 0);
    endtask

    task automatic return_result(input logic [37:0] v, input int delay, input bit push, input bit ovr);
        for (int i = 0; i < delay; i++) begin
            rx_data  = 8'($urandom);
            rx_valid = ovr && ($urandom_range(3) == 0);
            tick();
        end
        rx_valid = 1'b0;
        if (push) for (int k = 0; k < 5; k++) exp_bytes.push_back(model_byte(v, k));
        fir_out       = v;
        fir_out_valid = 1'b1;
        tick();
        fir_out_valid = 1'b0;
        check("tx_valid_m1", tx_valid, 1);
    endtask

    task automatic finish_tx(input bit rnd, output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            tx_ready      = rnd ? ($urandom_range(1) == 1) : 1'b1;
            rx_data       = 8'($urandom);
            rx_valid      = rnd && ($urandom_range(4) == 0);
            fir_out_valid = rnd && ($urandom_range(4) == 0);
            fir_out       = 38'h15_5555_5555;
            tick();
            cycles++;
        end
        rx_valid      = 1'b0;
        fir_out_valid = 1'b0;
        if (cycles >= 200) fail_now("finish_tx_bound");
        check("idle_busy", busy, 0);
        check("idle_tx_valid", tx_valid, 0);
        check("idle_bytes_left", exp_bytes.size(), 0);
    endtask

    initial begin
        int cyc;
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int           cyc;
        logic [63:0]  r;
        logic [37:0]  v;
        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; fir_out = '0;
        fir_out_valid = 1'b0; tx_ready = 1'b1;
        tick(); tick();
        check("rst_fir_in", fir_in, 0);
        check("rst_fir_valid", fir_valid, 0);
        check("rst_tx", {tx_valid, tx_data}, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {overrun, timeout}, 0);
        rst = 1'b0;
        tick();

        // 0x34, 0x12 -> 0x1234; result 0x102 with byte 0 stalled for 3 cycles.
        send_sample(16'h1234, 0, 1'b0, 1'b0);
        tx_ready = 1'b0;
        exp_bytes = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00};
        return_result(38'h00_0000_0102, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_data", tx_data, 8'h02);
            check("stall_valid", tx_valid, 1);
            tick();
        end
        tx_ready = 1'b1;
        tick();
        check("byte1_after_ready", tx_data, 8'h01);
        finish_tx(1'b0, cyc);
        check("tail_cycles", cyc, 4);

        // Negative result: top byte must be sign-filled.
        send_sample(16'hBEEF, 2, 1'b1, 1'b0);
        exp_bytes = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        return_result(38'h3F_FFFF_FFFE, 3, 1'b0, 1'b0);
        finish_tx(1'b0, cyc);
        check("consecutive_cycles", cyc, 5);

        // Stray byte in WAIT: single overrun pulse, result unchanged.
        send_sample(16'h00FF, 0, 1'b0, 1'b0);
        send_byte(8'hAA);
        check("overrun_pulse", overrun, 1);
        tick();
        check("overrun_once", overrun, 0);
        exp_bytes = '{8'h81, 8'h0F, 8'hC3, 8'hA5, 8'h15};
        return_result(38'h15_A5C3_0F81, 1, 1'b0, 1'b0);
        finish_tx(1'b0, cyc);
        send_sample(16'hC3A5, 0, 1'b0, 1'b0);
        return_result(38'h00_0000_0000, 0, 1'b1, 1'b0);
        finish_tx(1'b0, cyc);

`ifdef FIR_SEQ_TIMEOUT_EN
        send_sample(16'h4242, 0, 1'b0, 1'b0);
        cyc = 0;
        while (!timeout && cyc < 200) begin
            tick();
            cyc++;
        end
        check("timeout_wait_cycles", cyc, 72);
        check("timeout_busy", busy, 0);
        check("timeout_tx_valid", tx_valid, 0);
        in_flight = 1'b0;
        tick();
`endif

        // Reset in the middle of SEND.
        send_sample(16'h9876, 0, 1'b0, 1'b0);
        return_result(38'h12_3456_789A, 0, 1'b1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_fir_in", fir_in, 0);
        check("midrst_strobes", {fir_valid, tx_valid, busy, overrun, timeout}, 0);
        check("midrst_tx_data", tx_data, 0);
        exp_bytes.delete();
        exp_samples.delete();
        in_flight = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        send_sample(16'h5678, 0, 1'b0, 1'b0);
        return_result(38'h01_0203_0405, 0, 1'b1, 1'b0);
        finish_tx(1'b0, cyc);

        // Randomized transactions against the arithmetic model.
        for (int t = 0; t < 40; t++) begin
            r = {$urandom(), $urandom()};
            case ($urandom_range(5))
                0:       v = 38'h00_0000_0000;
                1:       v = 38'h3F_FFFF_FFFF;
                2:       v = 38'h20_0000_0000;
                3:       v = 38'h1F_FFFF_FFFF;
                default: v = r[37:0];
            endcase
            send_sample(16'($urandom), $urandom_range(3), 1'b1, $urandom_range(1) == 1);
            return_result(v, $urandom_range(6), 1'b1, 1'b1);
            finish_tx(1'b1, cyc);
        end

        tick(); tick();
        check("samples_left", exp_samples.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
